wb_syscon_seq: RTL and testbench

//  Synthesisable, parametrised Wishbone system controller. Takes the board clock and external reset, and

---
 rtl/wb_syscon_seq.sv | 170 +++++++++++++++++
 tb/tb_wb_syscon_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_syscon_seq.sv
// Wishbone system controller: synchronised, stretched and staggered per-channel resets,
// software reset, reset cause and cycle timestamp. Optional watchdog: WB_SYSCON_WDT_EN.
module wb_syscon_seq #(
  parameter int NCH        = 3,
  parameter int RST_CYCLES = 4,
  parameter int STAGGER    = 2,
  parameter int STAMP_W    = 32,
  parameter int WDT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  input  logic               wdt_kick,
  output logic [NCH-1:0]     rst_out,
  output logic               rst_done,
  output logic [1:0]         rst_cause,
  output logic [STAMP_W-1:0] stamp
);

  localparam int LAST = RST_CYCLES + STAGGER * (NCH - 1);
  localparam int CW   = (LAST > 0) ? $clog2(LAST + 1) : 1;

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  // Release threshold of channel idx, counted in edges after the synchronised release.
  function automatic logic [CW-1:0] thr(input int idx);
    return CW'(RST_CYCLES + STAGGER * idx);
  endfunction

  logic [1:0]     sync_r;
  logic           rst_sync_s;
  logic [1:0]     state_r;
  logic [1:0]     state_nx_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nx_s;
  logic [CW-1:0]  cnt_inc_s;
  logic [NCH-1:0] rel_s;
  logic [NCH-1:0] rst_out_nx_s;
  logic           done_nx_s;
  logic [1:0]     cause_nx_s;
  logic           counting_s;
  logic           take_s;
  logic           wdt_timeout_s;

  assign rst_sync_s = sync_r[1];

  // Two-flop reset synchroniser: asynchronous clear, synchronous release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], 1'b1};
    end
  end

  // Timestamp counts every edge from the synchronised release onward; only rst clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp <= {STAMP_W{1'b0}};
    end else if (sync_r[0]) begin
      stamp <= stamp + {{(STAMP_W-1){1'b0}}, 1'b1};
    end else begin
      stamp <= stamp;
    end
  end

`ifdef WB_SYSCON_WDT_EN
  localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  logic [WW-1:0] wdt_r;

  assign wdt_timeout_s = (state_r == S_RUN) && !wdt_kick && (wdt_r == WW'(WDT_CYCLES - 1));

  // Watchdog counter: runs only in RUN, restarted by a kick or by leaving RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_r <= {WW{1'b0}};
    end else if ((state_r != S_RUN) || wdt_kick || take_s) begin
      wdt_r <= {WW{1'b0}};
    end else begin
      wdt_r <= wdt_r + {{(WW-1){1'b0}}, 1'b1};
    end
  end
`else
  logic wdt_unused_s;
  assign wdt_unused_s  = wdt_kick | (WDT_CYCLES == 0);
  assign wdt_timeout_s = 1'b0;
`endif

  assign counting_s = ((state_r == S_HOLD) && rst_sync_s) ||
                      (state_r == S_STRETCH) || (state_r == S_RELEASE);
  assign take_s     = (state_r == S_RUN) && (sw_rst_req || wdt_timeout_s);
  assign cnt_inc_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};

  // Per-channel release flags for the edge being evaluated.
  always_comb begin
    rel_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      rel_s[i] = (cnt_inc_s >= thr(i));
    end
  end

  // Sequencer next-state: HOLD -> STRETCH -> RELEASE -> RUN, RUN re-enters STRETCH on soft reset.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    rst_out_nx_s = rst_out;
    done_nx_s    = rst_done;
    cause_nx_s   = rst_cause;
    case (state_r)
      S_HOLD, S_STRETCH, S_RELEASE: begin
        if (counting_s) begin
          cnt_nx_s     = cnt_inc_s;
          rst_out_nx_s = rst_out & ~rel_s;
          if (cnt_inc_s == CW'(LAST)) begin
            state_nx_s = S_RUN;
            done_nx_s  = 1'b1;
          end else if (rel_s[0]) begin
            state_nx_s = S_RELEASE;
          end else begin
            state_nx_s = S_STRETCH;
          end
        end else begin
          state_nx_s = S_HOLD;
        end
      end
      S_RUN: begin
        if (take_s) begin
          state_nx_s   = S_STRETCH;
          cnt_nx_s     = {CW{1'b0}};
          rst_out_nx_s = {NCH{1'b1}};
          done_nx_s    = 1'b0;
          cause_nx_s   = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      default: begin
        state_nx_s   = S_HOLD;
        cnt_nx_s     = {CW{1'b0}};
        rst_out_nx_s = {NCH{1'b1}};
        done_nx_s    = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers; rst low forces the external-reset values immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_HOLD;
      cnt_r     <= {CW{1'b0}};
      rst_out   <= {NCH{1'b1}};
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_EXT;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      rst_out   <= rst_out_nx_s;
      rst_done  <= done_nx_s;
      rst_cause <= cause_nx_s;
    end
  end

endmodule

// File: tb/tb_wb_syscon_seq.sv
// Directed self-checking bench for wb_syscon_seq (NCH=3, RST_CYCLES=4, STAGGER=2, STAMP_W=8).
module tb_wb_syscon_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst_req;
  logic       wdt_kick;
  logic [2:0] rst_out;
  logic       rst_done;
  logic [1:0] rst_cause;
  logic [7:0] stamp;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  wb_syscon_seq #(
    .NCH(3), .RST_CYCLES(4), .STAGGER(2), .STAMP_W(8), .WDT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdt_kick(wdt_kick),
    .rst_out(rst_out), .rst_done(rst_done), .rst_cause(rst_cause), .stamp(stamp)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Releases rst and checks the full power-up release sequence edge by edge.
  task automatic powerup(input string p);
    rst = 1'b1;
    step(1);
    chk({p, "_e1_out"}, 32'(rst_out), 32'h7);
    chk({p, "_e1_stamp"}, 32'(stamp), 32'd0);
    step(1);
    chk({p, "_e2_stamp"}, 32'(stamp), 32'd1);
    step(3);
    chk({p, "_e5_out"}, 32'(rst_out), 32'h7);
    step(1);
    chk({p, "_e6_out"}, 32'(rst_out), 32'h6);
    step(1);
    chk({p, "_e7_out"}, 32'(rst_out), 32'h6);
    step(1);
    chk({p, "_e8_out"}, 32'(rst_out), 32'h4);
    step(1);
    chk({p, "_e9_out"}, 32'(rst_out), 32'h4);
    chk({p, "_e9_done"}, 32'(rst_done), 32'd0);
    step(1);
    chk({p, "_e10_out"}, 32'(rst_out), 32'h0);
    chk({p, "_e10_done"}, 32'(rst_done), 32'd1);
    chk({p, "_e10_cause"}, 32'(rst_cause), 32'h1);
    chk({p, "_e10_stamp"}, 32'(stamp), 32'd9);
  endtask

  initial begin
    rst        = 1'b0;
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
    step(2);
    chk("rst_out", 32'(rst_out), 32'h7);
    chk("rst_done", 32'(rst_done), 32'd0);
    chk("rst_cause", 32'(rst_cause), 32'h1);
    chk("rst_stamp", 32'(stamp), 32'd0);
    step(3);
    powerup("t1");

    // Test 2: one-cycle software reset sampled at edge 13.
    step(2);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk("t2_n_out", 32'(rst_out), 32'h7);
    chk("t2_n_done", 32'(rst_done), 32'd0);
    chk("t2_n_cause", 32'(rst_cause), 32'h2);
    chk("t2_n_stamp", 32'(stamp), 32'd12);
    step(3);
    chk("t2_n3_out", 32'(rst_out), 32'h7);
    step(1);
    chk("t2_n4_out", 32'(rst_out), 32'h6);
    step(2);
    chk("t2_n6_out", 32'(rst_out), 32'h4);
    step(2);
    chk("t2_n8_out", 32'(rst_out), 32'h0);
    chk("t2_n8_done", 32'(rst_done), 32'd1);
    chk("t2_n8_cause", 32'(rst_cause), 32'h2);
    chk("t2_n8_stamp", 32'(stamp), 32'd20);

    // Test 3: request held through RELEASE is taken again on the next RUN entry.
    sw_rst_req = 1'b1;
    step(1);
    chk("t3_e22_out", 32'(rst_out), 32'h7);
    step(4);
    chk("t3_e26_out", 32'(rst_out), 32'h6);
    step(2);
    chk("t3_e28_out", 32'(rst_out), 32'h4);
    step(2);
    chk("t3_e30_out", 32'(rst_out), 32'h0);
    chk("t3_e30_done", 32'(rst_done), 32'd1);
    step(1);
    sw_rst_req = 1'b0;
    chk("t3_e31_out", 32'(rst_out), 32'h7);
    chk("t3_e31_done", 32'(rst_done), 32'd0);
    step(8);
    chk("t3_e39_out", 32'(rst_out), 32'h0);
    chk("t3_e39_done", 32'(rst_done), 32'd1);
    step(217);
    chk("t3_e256_stamp", 32'(stamp), 32'd255);
    step(1);
    chk("t3_e257_stamp", 32'(stamp), 32'd0);
    step(1);
    chk("t3_e258_stamp", 32'(stamp), 32'd1);

    // Test 4: external reset pulse in the middle of RELEASE.
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    step(6);
    chk("t4_mid_out", 32'(rst_out), 32'h4);
    rst = 1'b0;
    #1;
    chk("t4_async_out", 32'(rst_out), 32'h7);
    chk("t4_async_stamp", 32'(stamp), 32'd0);
    chk("t4_async_cause", 32'(rst_cause), 32'h1);
    chk("t4_async_done", 32'(rst_done), 32'd0);
    step(1);
    powerup("t4");

`ifdef WB_SYSCON_WDT_EN
    // Test 5: watchdog timeout, periodic kicks, kick on the terminal edge.
    step(15);
    chk("t5_pre_done", 32'(rst_done), 32'd1);
    step(1);
    chk("t5_to_out", 32'(rst_out), 32'h7);
    chk("t5_to_cause", 32'(rst_cause), 32'h3);
    chk("t5_to_done", 32'(rst_done), 32'd0);
    step(8);
    chk("t5_run_out", 32'(rst_out), 32'h0);
    chk("t5_run_cause", 32'(rst_cause), 32'h3);
    for (int k = 0; k < 20; k++) begin
      step(9);
      wdt_kick = 1'b1;
      step(1);
      wdt_kick = 1'b0;
      chk("t5_kick_done", 32'(rst_done), 32'd1);
    end
    step(15);
    wdt_kick = 1'b1;
    step(1);
    wdt_kick = 1'b0;
    chk("t5_term_kick_done", 32'(rst_done), 32'd1);
    chk("t5_term_kick_out", 32'(rst_out), 32'h0);
    step(15);
    chk("t5_again_pre", 32'(rst_done), 32'd1);
    step(1);
    chk("t5_again_out", 32'(rst_out), 32'h7);
    chk("t5_again_cause", 32'(rst_cause), 32'h3);
`else
    // Test 6: without the watchdog, an unkicked RUN stays put.
    step(200);
    chk("t6_done", 32'(rst_done), 32'd1);
    chk("t6_cause", 32'(rst_cause), 32'h1);
    chk("t6_out", 32'(rst_out), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
